serv_bus_arbiter: RTL and testbench
===================================

Name: serv_bus_arbiter

Overview:
- Shares one single-port 32-bit instruction/data RAM and one peripheral port between SERV's ibus and dbus.
- Sits between serv_top and the RAM/GPIO/peripheral logic in the Tang Nano top level.
- Decodes each request to RAM or peripheral and sequences the RAM's 1-cycle read latency.
- Returns single-cycle acks and bounds peripheral stalls with a timeout.

Parameters:
RAM_AW, 10, RAM word-address width (1024 words = 4 KiB)
PER_SEL_BIT, 30, address bit that selects the peripheral region when 1
TIMEOUT, 16, max cycles o_per_stb is held without i_per_ack before forced completion (>=2)

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
i_ibus_adr  in  32  instruction address
i_ibus_cyc  in  1  instruction request
o_ibus_rdt  out  32  instruction read data, valid while o_ibus_ack=1
o_ibus_ack  out  1  one-cycle instruction completion
i_dbus_adr  in  32  data address
i_dbus_dat  in  32  write data
i_dbus_sel  in  4  byte enables
i_dbus_we  in  1  write when 1
i_dbus_cyc  in  1  data request
o_dbus_rdt  out  32  data read data, valid while o_dbus_ack=1
o_dbus_ack  out  1  one-cycle data completion
o_ram_addr  out  RAM_AW  word address (adr[RAM_AW+1:2])
o_ram_ce  out  1  RAM access strobe
o_ram_we  out  4  RAM byte write mask; 0 for reads and all ibus accesses
o_ram_wdata  out  32  RAM write data
i_ram_rdata  in  32  RAM read data, valid 1 cycle after o_ram_ce
o_per_adr  out  32  peripheral address
o_per_dat  out  32  peripheral write data
o_per_sel  out  4  peripheral byte enables
o_per_we  out  1  peripheral write
o_per_stb  out  1  peripheral request, held until ack or timeout
i_per_rdt  in  32  peripheral read data, sampled with i_per_ack
i_per_ack  in  1  peripheral completion
o_bus_err  out  1  one-cycle pulse on peripheral timeout

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; all outputs 0; timeout counter 0. Any in-flight transfer is dropped and never acked.
- All outputs are registered.
- States: IDLE, RAM, RDATA, PER, RESP.
- IDLE: master selection
  - i_dbus_cyc=1 selects dbus; otherwise i_ibus_cyc=1 selects ibus. dbus wins when both are asserted.
  - The selected address, data, sel and we are latched. The ibus forces we=0, sel=4'hF.
  - Latched adr[PER_SEL_BIT]=0 -> RAM; =1 -> PER. ibus requests into the peripheral region are legal.
- RAM (1 cycle): o_ram_ce=1, o_ram_addr from latched adr. o_ram_we=sel if we=1, else 0. -> RDATA.
- RDATA (1 cycle): captures i_ram_rdata into the rdt register. -> RESP.
- PER: o_per_stb=1 with latched fields, held stable.
  - i_per_ack=1: capture i_per_rdt -> RESP.
  - Counter reaching TIMEOUT-1 without ack: rdt=32'h0, o_bus_err=1 for 1 cycle -> RESP.
  - If i_per_ack and timeout coincide, the ack wins (no error).
- RESP (1 cycle): the granted master's ack=1 with rdt driven; the other master's ack stays 0. -> IDLE.
  - rdt is 0 outside RESP.
  - Writes return rdt = captured RAM/peripheral data; value is don't-care for the master.
- Latency from cyc sampled in IDLE to ack: RAM = 3 cycles; peripheral = 2 + wait cycles. Minimum 1 idle cycle between consecutive grants.
- A cyc deasserted before ack is ignored; the transfer completes and the ack is still issued.
- RAM addresses above 2^RAM_AW words wrap (bits above RAM_AW+1 ignored, except PER_SEL_BIT).
- The unselected master's cyc is left pending and served in the next IDLE.

Decomposition:
- Package serv_soc_pkg holds:
  - state enum arb_state_t {IDLE, RAM, RDATA, PER, RESP}
  - master enum master_t {M_IBUS, M_DBUS}
  - localparam RDT_ERR = 32'h0
- Single flat module; no sub-module. The timeout counter is $clog2(TIMEOUT) bits, inline.

Test Plan:
- Reset with i_ibus_cyc=1, adr=0x0, RAM word0=0x00000013 -> o_ram_ce at cycle 1, o_ibus_ack=1 at cycle 3 with o_ibus_rdt=0x00000013; all outputs 0 while resetn=0.
- dbus write adr=0x8, dat=0xA5A5A5A5, sel=4'b0011 -> o_ram_we=4'b0011, o_ram_addr=2, o_dbus_ack at cycle 3; ibus read of 0x8 then returns 0x????A5A5 merged with prior contents.
- ibus_cyc and dbus_cyc both rise in the same cycle -> dbus acked first (cycle 3), ibus acked cycle 7, never both acks high.
- dbus read adr=0x40000100, peripheral acks after 4 cycles with rdt=0x1 -> o_per_stb high 4 cycles, o_dbus_rdt=0x1, o_bus_err=0.
- Peripheral never acks (TIMEOUT=16) -> o_per_stb drops after 16 cycles, o_bus_err pulses once, o_dbus_ack=1 with rdt=0.
- resetn pulled low while in PER -> outputs 0 immediately (asynchronous). After release, with cyc still high, a fresh transfer starts and completes normally.

Source files
------------

// File: rtl/serv_soc_pkg.sv
// Shared types for the SERV SoC bus arbiter: FSM states, master identity,
// and the read data returned on a peripheral timeout.
package serv_soc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM,
        RDATA,
        PER,
        RESP
    } arb_state_t;

    typedef enum logic {
        M_IBUS,
        M_DBUS
    } master_t;

    localparam logic [31:0] RDT_ERR = 32'h0;

endpackage

// File: rtl/serv_bus_arbiter.sv
// Shares a single-port RAM and one peripheral port between SERV's ibus and dbus.
// Every output is registered; dbus has priority and each grant runs to its ack.
module serv_bus_arbiter
    import serv_soc_pkg::*;
#(
    parameter int RAM_AW      = 10,
    parameter int PER_SEL_BIT = 30,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       i_ibus_adr,
    input  logic              i_ibus_cyc,
    output logic [31:0]       o_ibus_rdt,
    output logic              o_ibus_ack,
    input  logic [31:0]       i_dbus_adr,
    input  logic [31:0]       i_dbus_dat,
    input  logic [3:0]        i_dbus_sel,
    input  logic              i_dbus_we,
    input  logic              i_dbus_cyc,
    output logic [31:0]       o_dbus_rdt,
    output logic              o_dbus_ack,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_ce,
    output logic [3:0]        o_ram_we,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic [31:0]       o_per_adr,
    output logic [31:0]       o_per_dat,
    output logic [3:0]        o_per_sel,
    output logic              o_per_we,
    output logic              o_per_stb,
    input  logic [31:0]       i_per_rdt,
    input  logic              i_per_ack,
    output logic              o_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state, state_d;
    master_t          mst_p0, mst_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic [31:0]       ibus_rdt_d, dbus_rdt_d;
    logic              ibus_ack_d, dbus_ack_d;
    logic [RAM_AW-1:0] ram_addr_d;
    logic              ram_ce_d;
    logic [3:0]        ram_we_d;
    logic [31:0]       ram_wdata_d;
    logic [31:0]       per_adr_d, per_dat_d;
    logic [3:0]        per_sel_d;
    logic              per_we_d, per_stb_d;
    logic              bus_err_d;

    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        req_we;
    master_t     req_mst;
    logic        resp_go;
    logic [31:0] resp_rdt;

    // Request selection: dbus wins; ibus accesses are always full-word reads.
    always_comb begin
        req_mst = M_IBUS;
        req_adr = i_ibus_adr;
        req_dat = 32'h0;
        req_sel = 4'hF;
        req_we  = 1'b0;
        if (i_dbus_cyc) begin
            req_mst = M_DBUS;
            req_adr = i_dbus_adr;
            req_dat = i_dbus_dat;
            req_sel = i_dbus_sel;
            req_we  = i_dbus_we;
        end
    end

    always_comb begin
        state_d     = state;
        mst_d       = mst_p0;
        cnt_d       = cnt;
        ibus_rdt_d  = 32'h0;
        dbus_rdt_d  = 32'h0;
        ibus_ack_d  = 1'b0;
        dbus_ack_d  = 1'b0;
        ram_addr_d  = '0;
        ram_ce_d    = 1'b0;
        ram_we_d    = 4'h0;
        ram_wdata_d = 32'h0;
        per_adr_d   = o_per_adr;
        per_dat_d   = o_per_dat;
        per_sel_d   = o_per_sel;
        per_we_d    = o_per_we;
        per_stb_d   = o_per_stb;
        bus_err_d   = 1'b0;
        resp_go     = 1'b0;
        resp_rdt    = 32'h0;

        case (state)
            IDLE: begin
                if (i_dbus_cyc || i_ibus_cyc) begin
                    mst_d = req_mst;
                    if (req_adr[PER_SEL_BIT]) begin
                        state_d   = PER;
                        per_adr_d = req_adr;
                        per_dat_d = req_dat;
                        per_sel_d = req_sel;
                        per_we_d  = req_we;
                        per_stb_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d     = RAM;
                        ram_ce_d    = 1'b1;
                        ram_addr_d  = req_adr[RAM_AW+1:2];
                        ram_we_d    = req_we ? req_sel : 4'h0;
                        ram_wdata_d = req_dat;
                    end
                end
            end
            RAM:   state_d = RDATA;
            RDATA: begin
                resp_go  = 1'b1;
                resp_rdt = i_ram_rdata;
            end
            PER: begin
                // An ack in the final allowed cycle beats the timeout.
                if (i_per_ack) begin
                    resp_go  = 1'b1;
                    resp_rdt = i_per_rdt;
                end else if (cnt == CNT_LAST) begin
                    resp_go   = 1'b1;
                    resp_rdt  = RDT_ERR;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (resp_go) begin
            state_d   = RESP;
            per_adr_d = 32'h0;
            per_dat_d = 32'h0;
            per_sel_d = 4'h0;
            per_we_d  = 1'b0;
            per_stb_d = 1'b0;
            if (mst_p0 == M_DBUS) begin
                dbus_ack_d = 1'b1;
                dbus_rdt_d = resp_rdt;
            end else begin
                ibus_ack_d = 1'b1;
                ibus_rdt_d = resp_rdt;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            mst_p0      <= M_IBUS;
            cnt         <= '0;
            o_ibus_rdt  <= 32'h0;
            o_ibus_ack  <= 1'b0;
            o_dbus_rdt  <= 32'h0;
            o_dbus_ack  <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_ce    <= 1'b0;
            o_ram_we    <= 4'h0;
            o_ram_wdata <= 32'h0;
            o_per_adr   <= 32'h0;
            o_per_dat   <= 32'h0;
            o_per_sel   <= 4'h0;
            o_per_we    <= 1'b0;
            o_per_stb   <= 1'b0;
            o_bus_err   <= 1'b0;
        end else begin
            state       <= state_d;
            mst_p0      <= mst_d;
            cnt         <= cnt_d;
            o_ibus_rdt  <= ibus_rdt_d;
            o_ibus_ack  <= ibus_ack_d;
            o_dbus_rdt  <= dbus_rdt_d;
            o_dbus_ack  <= dbus_ack_d;
            o_ram_addr  <= ram_addr_d;
            o_ram_ce    <= ram_ce_d;
            o_ram_we    <= ram_we_d;
            o_ram_wdata <= ram_wdata_d;
            o_per_adr   <= per_adr_d;
            o_per_dat   <= per_dat_d;
            o_per_sel   <= per_sel_d;
            o_per_we    <= per_we_d;
            o_per_stb   <= per_stb_d;
            o_bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Scoreboard bench for serv_bus_arbiter: RAM and peripheral models, masters
// issuing directed transfers, and a monitor checking every ack against a queue.
module tb_serv_bus_arbiter;
    import serv_soc_pkg::*;

    localparam int RAM_AW      = 10;
    localparam int PER_SEL_BIT = 30;
    localparam int TIMEOUT     = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [31:0]       i_ibus_adr;
    logic              i_ibus_cyc;
    logic [31:0]       o_ibus_rdt;
    logic              o_ibus_ack;
    logic [31:0]       i_dbus_adr;
    logic [31:0]       i_dbus_dat;
    logic [3:0]        i_dbus_sel;
    logic              i_dbus_we;
    logic              i_dbus_cyc;
    logic [31:0]       o_dbus_rdt;
    logic              o_dbus_ack;
    logic [RAM_AW-1:0] o_ram_addr;
    logic              o_ram_ce;
    logic [3:0]        o_ram_we;
    logic [31:0]       o_ram_wdata;
    logic [31:0]       i_ram_rdata;
    logic [31:0]       o_per_adr;
    logic [31:0]       o_per_dat;
    logic [3:0]        o_per_sel;
    logic              o_per_we;
    logic              o_per_stb;
    logic [31:0]       i_per_rdt;
    logic              i_per_ack;
    logic              o_bus_err;

    always #5 clk = ~clk;

    serv_bus_arbiter #(
        .RAM_AW(RAM_AW), .PER_SEL_BIT(PER_SEL_BIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_ram_addr(o_ram_addr), .o_ram_ce(o_ram_ce), .o_ram_we(o_ram_we),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
        .o_per_adr(o_per_adr), .o_per_dat(o_per_dat), .o_per_sel(o_per_sel),
        .o_per_we(o_per_we), .o_per_stb(o_per_stb),
        .i_per_rdt(i_per_rdt), .i_per_ack(i_per_ack), .o_bus_err(o_bus_err)
    );

    // RAM model: synchronous read-before-write with byte enables.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (o_ram_ce) begin
            i_ram_rdata <= mem[o_ram_addr];
            for (int b = 0; b < 4; b++)
                if (o_ram_we[b]) mem[o_ram_addr][b*8 +: 8] = o_ram_wdata[b*8 +: 8];
        end
    end

    // Peripheral model: ack in the per_wait-th strobe cycle; per_wait=0 never acks.
    int          per_wait = 0;
    int          per_cnt  = 0;
    logic [31:0] per_rdata = 32'h0;
    always @(posedge clk) per_cnt <= o_per_stb ? per_cnt + 1 : 0;
    assign i_per_ack = o_per_stb && (per_wait != 0) && (per_cnt == per_wait - 1);
    assign i_per_rdt = per_rdata;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic any_out;
    assign any_out = |{o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_ram_addr, o_ram_ce,
                       o_ram_we, o_ram_wdata, o_per_adr, o_per_dat, o_per_sel, o_per_we,
                       o_per_stb, o_bus_err};

    // Observers of the most recent RAM/peripheral access and strobe length.
    int                stb_run = 0, stb_last = 0, err_cnt = 0;
    logic [RAM_AW-1:0] s_addr;
    logic [3:0]        s_we, s_per_sel;
    logic [31:0]       s_wdata, s_per_adr, s_per_dat;
    logic              s_per_we;
    always @(negedge clk) begin
        if (o_per_stb) stb_run <= stb_run + 1;
        else if (stb_run != 0) begin
            stb_last <= stb_run;
            stb_run  <= 0;
        end
        if (o_bus_err) err_cnt <= err_cnt + 1;
        if (o_ram_ce) begin
            s_addr  <= o_ram_addr;
            s_we    <= o_ram_we;
            s_wdata <= o_ram_wdata;
        end
        if (o_per_stb) begin
            s_per_adr <= o_per_adr;
            s_per_dat <= o_per_dat;
            s_per_sel <= o_per_sel;
            s_per_we  <= o_per_we;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          dbus;
        logic [31:0] rdt;
        bit          chk_rdt;
        bit          err;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit dbus, input logic [31:0] rdt, input bit chk_rdt, input bit err);
        exp_t e;
        e.dbus = dbus; e.rdt = rdt; e.chk_rdt = chk_rdt; e.err = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn && (o_ibus_ack || o_dbus_ack)) begin
            chk("dual_ack", o_ibus_ack && o_dbus_ack, 0);
            if (sb.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                e = sb.pop_front();
                chk("ack_master", o_dbus_ack, e.dbus);
                if (e.chk_rdt) chk("ack_rdt", e.dbus ? o_dbus_rdt : o_ibus_rdt, e.rdt);
                chk("other_rdt_zero", e.dbus ? o_ibus_rdt : o_dbus_rdt, 0);
                chk("ack_bus_err", o_bus_err, e.err);
            end
        end
    end

    task automatic wait_ack(input bit dbus, input int k, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dbus ? o_dbus_ack : o_ibus_ack) begin
                lat = cyc_n - k;
                break;
            end
        end
        if (lat < 0) chk(dbus ? "dbus_ack_timeout" : "ibus_ack_timeout", 1, 0);
    endtask

    task automatic dbus_xfer(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we, output int lat);
        int k;
        i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we;
        i_dbus_cyc = 1'b1;
        k = cyc_n;
        wait_ack(1'b1, k, lat);
        i_dbus_cyc = 1'b0;
    endtask

    task automatic ibus_xfer(input logic [31:0] adr, output int lat);
        int k;
        i_ibus_adr = adr;
        i_ibus_cyc = 1'b1;
        k = cyc_n;
        wait_ack(1'b0, k, lat);
        i_ibus_cyc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, k, e0;
        resetn = 1'b0;
        i_ibus_adr = 32'h0; i_ibus_cyc = 1'b1;
        i_dbus_adr = 32'h0; i_dbus_dat = 32'h0; i_dbus_sel = 4'h0;
        i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'hCAFE_F00D;
        mem[2] = 32'h1234_5678;

        // Reset held with ibus request pending
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero_a", any_out, 0);
        @(negedge clk);
        chk("reset_outputs_zero_b", any_out, 0);
        push(1'b0, 32'h0000_0013, 1'b1, 1'b0);
        k = cyc_n;
        resetn = 1'b1;
        @(negedge clk);
        chk("t1_ram_ce_cycle1", o_ram_ce, 1);
        chk("t1_ram_addr", o_ram_addr, 0);
        chk("t1_ram_we_read", o_ram_we, 0);
        wait_ack(1'b0, k, lat);
        i_ibus_cyc = 1'b0;
        chk("t1_latency", lat, 3);
        @(negedge clk);

        // dbus partial write
        push(1'b1, 32'h0, 1'b0, 1'b0);
        dbus_xfer(32'h0000_0008, 32'hA5A5_A5A5, 4'b0011, 1'b1, lat);
        chk("t2_latency", lat, 3);
        chk("t2_ram_we", s_we, 4'b0011);
        chk("t2_ram_addr", s_addr, 2);
        chk("t2_ram_wdata", s_wdata, 32'hA5A5_A5A5);
        @(negedge clk);

        // Simultaneous requests: dbus first, then ibus reads back the merged word
        push(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
        push(1'b0, 32'h1234_A5A5, 1'b1, 1'b0);
        fork
            dbus_xfer(32'h0000_0004, 32'h0, 4'hF, 1'b0, lat);
            ibus_xfer(32'h0000_0008, lat2);
        join
        chk("t3_dbus_latency", lat, 3);
        chk("t3_ibus_latency", lat2, 7);
        @(negedge clk);

        // Address wrap beyond RAM size
        push(1'b0, 32'h1234_A5A5, 1'b1, 1'b0);
        ibus_xfer(32'h0000_1008, lat);
        chk("t4_wrap_addr", s_addr, 2);
        chk("t4_latency", lat, 3);
        @(negedge clk);

        // Peripheral read, ack in 4th strobe cycle
        per_wait = 4; per_rdata = 32'h0000_0001;
        e0 = err_cnt;
        push(1'b1, 32'h0000_0001, 1'b1, 1'b0);
        dbus_xfer(32'h4000_0100, 32'h0, 4'hF, 1'b0, lat);
        chk("t5_latency", lat, 5);
        @(negedge clk);
        chk("t5_stb_cycles", stb_last, 4);
        chk("t5_no_err", err_cnt - e0, 0);
        chk("t5_per_adr", s_per_adr, 32'h4000_0100);
        chk("t5_per_we", s_per_we, 0);

        // Peripheral never acks -> timeout
        per_wait = 0;
        e0 = err_cnt;
        push(1'b1, 32'h0, 1'b1, 1'b1);
        dbus_xfer(32'h4000_0200, 32'h0, 4'hF, 1'b0, lat);
        chk("t6_latency", lat, 17);
        @(negedge clk);
        chk("t6_stb_cycles", stb_last, TIMEOUT);
        chk("t6_err_pulses", err_cnt - e0, 1);

        // Ack in the last allowed cycle wins over the timeout
        per_wait = TIMEOUT; per_rdata = 32'hBEEF_0016;
        e0 = err_cnt;
        push(1'b1, 32'hBEEF_0016, 1'b1, 1'b0);
        dbus_xfer(32'h4000_0204, 32'h0, 4'hF, 1'b0, lat);
        chk("t7_latency", lat, 17);
        @(negedge clk);
        chk("t7_stb_cycles", stb_last, TIMEOUT);
        chk("t7_no_err", err_cnt - e0, 0);

        // ibus fetch from peripheral region
        per_wait = 1; per_rdata = 32'h600D_CAFE;
        push(1'b0, 32'h600D_CAFE, 1'b1, 1'b0);
        ibus_xfer(32'h4000_0010, lat);
        chk("t8_latency", lat, 2);
        chk("t8_per_sel", s_per_sel, 4'hF);
        chk("t8_per_we", s_per_we, 0);
        @(negedge clk);

        // dbus peripheral write carries data, sel and we
        per_wait = 2; per_rdata = 32'h0;
        push(1'b1, 32'h0, 1'b0, 1'b0);
        dbus_xfer(32'h4000_0020, 32'h1122_3344, 4'b1100, 1'b1, lat);
        chk("t9_per_we", s_per_we, 1);
        chk("t9_per_sel", s_per_sel, 4'b1100);
        chk("t9_per_dat", s_per_dat, 32'h1122_3344);
        @(negedge clk);

        // Asynchronous reset during PER, then a fresh transfer from held cyc
        per_wait = 0;
        i_dbus_adr = 32'h4000_0300; i_dbus_sel = 4'hF; i_dbus_we = 1'b0;
        i_dbus_cyc = 1'b1;
        repeat (4) @(negedge clk);
        chk("t10_stb_before_reset", o_per_stb, 1);
        #2 resetn = 1'b0;
        #1 chk("t10_async_reset_zero", any_out, 0);
        @(negedge clk);
        per_wait = 2; per_rdata = 32'h0000_55AA;
        push(1'b1, 32'h0000_55AA, 1'b1, 1'b0);
        k = cyc_n;
        resetn = 1'b1;
        wait_ack(1'b1, k, lat);
        i_dbus_cyc = 1'b0;
        chk("t10_latency", lat, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
